// File: rtl/alu_arb_pkg.sv
// ============================================================================
// Module : alu_arb_pkg
// Brief  : Shared types and widths for the ALU request arbiter.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package alu_arb_pkg;

  localparam int ALU_CTL_W  = 2;
  localparam int ALU_DATA_W = 8;
  localparam int STAT_W     = 16;

  typedef struct packed {
    logic [ALU_CTL_W-1:0]  ctl;
    logic [ALU_DATA_W-1:0] a;
    logic [ALU_DATA_W-1:0] b;
    logic                  ci;
  } alu_op_t;

endpackage

`default_nettype wire

// File: rtl/alu_arb_tag_fifo.sv
// ============================================================================
// Module : alu_arb_tag_fifo
// Brief  : DEPTH x W synchronous FIFO holding the requester tag of each op
//          in flight through the ALU. DEPTH must be a power of two (>=2).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module alu_arb_tag_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 2,
  localparam int PW   = $clog2(DEPTH),
  localparam int CW   = PW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_i,
  input  logic [W-1:0]  data_i,
  input  logic          pop_i,
  output logic [W-1:0]  head_o,
  output logic [CW-1:0] count_o,
  output logic          full_o,
  output logic          empty_o
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_q, rd_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          w_do_push, w_do_pop;

  assign full_o    = (cnt_q == CW'(DEPTH));
  assign empty_o   = (cnt_q == '0);
  assign w_do_push = push_i & ~full_o;
  assign w_do_pop  = pop_i & ~empty_o;
  assign head_o    = mem_q[rd_q];
  assign count_o   = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (w_do_push && !w_do_pop) cnt_d = cnt_q + 1'b1;
    if (!w_do_push && w_do_pop) cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (w_do_push) wr_q <= wr_q + 1'b1;
      if (w_do_pop)  rd_q <= rd_q + 1'b1;
      cnt_q <= cnt_d;
    end
  end

  // Storage needs no reset: entries are only read once the count covers them.
  always_ff @(posedge clk) begin
    if (w_do_push) mem_q[wr_q] <= data_i;
  end

endmodule

`default_nettype wire

// File: rtl/alu_req_arbiter.sv
// ============================================================================
// Module : alu_req_arbiter
// Brief  : Round-robin sharing of one ALU between NREQ push/stop requesters,
//          with in-order return routing. Optional macro ALU_ARB_STATS_EN adds
//          per-requester saturating accept counters on grant_cnt.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module alu_req_arbiter
  import alu_arb_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int DEPTH = 4,
  parameter int TAG_W = $clog2(NREQ)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NREQ-1:0]            req_push,
  output logic [NREQ-1:0]            req_stop,
  input  logic [ALU_CTL_W*NREQ-1:0]  req_ctl,
  input  logic [ALU_DATA_W*NREQ-1:0] req_a,
  input  logic [ALU_DATA_W*NREQ-1:0] req_b,
  input  logic [NREQ-1:0]            req_ci,
  output logic                       alu_pushin,
  input  logic                       alu_stopout,
  output logic [ALU_CTL_W-1:0]       alu_ctl,
  output logic [ALU_DATA_W-1:0]      alu_a,
  output logic [ALU_DATA_W-1:0]      alu_b,
  output logic                       alu_ci,
  input  logic                       alu_pushout,
  output logic                       alu_stopin,
  input  logic [ALU_DATA_W-1:0]      alu_z,
  input  logic                       alu_cout,
  output logic [NREQ-1:0]            rsp_push,
  input  logic [NREQ-1:0]            rsp_stop,
  output logic [ALU_DATA_W-1:0]      rsp_z,
  output logic                       rsp_cout,
`ifdef ALU_ARB_STATS_EN
  output logic [STAT_W*NREQ-1:0]     grant_cnt,
`endif
  output logic                       err_orphan
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [TAG_W-1:0] rr_ptr_q, rr_ptr_d, g_q, g_d;
  logic             lock_q, lock_d, err_q;
  logic [TAG_W-1:0] w_grant, w_head;
  logic             w_has_grant, w_can_issue, w_accept, w_pop;
  logic [CW-1:0]    w_count;
  logic             w_empty, w_unused_full;
  alu_op_t          w_op;

  always_comb begin
    int idx;
    idx         = 0;
    w_grant     = rr_ptr_q;
    w_has_grant = 1'b0;
    if (lock_q) begin
      w_grant     = g_q;
      w_has_grant = 1'b1;
    end else begin
      for (int k = 0; k < NREQ; k++) begin
        idx = int'(rr_ptr_q) + k;
        if (idx >= NREQ) idx = idx - NREQ;
        if (!w_has_grant && req_push[idx]) begin
          w_has_grant = 1'b1;
          w_grant     = TAG_W'(idx);
        end
      end
    end
  end

  assign w_can_issue = (w_count < CW'(DEPTH));

  always_comb begin
    w_op = '0;
    if (w_has_grant) begin
      w_op.ctl = req_ctl[ALU_CTL_W*int'(w_grant) +: ALU_CTL_W];
      w_op.a   = req_a[ALU_DATA_W*int'(w_grant) +: ALU_DATA_W];
      w_op.b   = req_b[ALU_DATA_W*int'(w_grant) +: ALU_DATA_W];
      w_op.ci  = req_ci[w_grant];
    end
  end

  assign alu_pushin = w_has_grant & w_can_issue & req_push[w_grant];
  assign alu_ctl    = w_op.ctl;
  assign alu_a      = w_op.a;
  assign alu_b      = w_op.b;
  assign alu_ci     = w_op.ci;
  assign w_accept   = alu_pushin & ~alu_stopout;

  always_comb begin
    req_stop = '1;
    if (w_has_grant && w_can_issue && !alu_stopout) req_stop[w_grant] = 1'b0;
  end

  // A stalled offer locks the grant so the ALU sees a stable op until taken.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    lock_d   = lock_q;
    g_d      = g_q;
    if (w_accept) begin
      rr_ptr_d = (w_grant == TAG_W'(NREQ - 1)) ? '0 : w_grant + 1'b1;
      lock_d   = 1'b0;
    end else if (alu_pushin) begin
      lock_d = 1'b1;
      g_d    = w_grant;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rr_ptr_q <= '0;
      lock_q   <= 1'b0;
      g_q      <= '0;
      err_q    <= 1'b0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      lock_q   <= lock_d;
      g_q      <= g_d;
      if (w_empty && alu_pushout) err_q <= 1'b1;
    end
  end

  alu_arb_tag_fifo #(
    .DEPTH (DEPTH),
    .W     (TAG_W)
  ) u_tag_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (w_accept),
    .data_i  (w_grant),
    .pop_i   (w_pop),
    .head_o  (w_head),
    .count_o (w_count),
    .full_o  (w_unused_full),
    .empty_o (w_empty)
  );

  always_comb begin
    rsp_push   = '0;
    alu_stopin = 1'b0;
    w_pop      = 1'b0;
    if (!w_empty) begin
      rsp_push[w_head] = alu_pushout;
      alu_stopin       = rsp_stop[w_head];
      w_pop            = alu_pushout & ~rsp_stop[w_head];
    end
  end

  assign rsp_z      = alu_z;
  assign rsp_cout   = alu_cout;
  assign err_orphan = err_q;

`ifdef ALU_ARB_STATS_EN
  for (genvar i = 0; i < NREQ; i++) begin : g_stats
    logic [STAT_W-1:0] cnt_q;
    always_ff @(posedge clk) begin
      if (!rst) cnt_q <= '0;
      else if (w_accept && (w_grant == TAG_W'(i)) && (cnt_q != '1)) cnt_q <= cnt_q + 1'b1;
    end
    assign grant_cnt[STAT_W*i +: STAT_W] = cnt_q;
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_alu_req_arbiter.sv
// ============================================================================
// Module : tb_alu_req_arbiter
// Brief  : Directed vector table plus hand sequences for alu_req_arbiter.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_alu_req_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_push, req_stop, req_ci, rsp_push, rsp_stop;
  logic [7:0]  req_ctl;
  logic [31:0] req_a, req_b;
  logic        alu_pushin, alu_stopout, alu_ci, alu_pushout, alu_stopin, alu_cout;
  logic [1:0]  alu_ctl;
  logic [7:0]  alu_a, alu_b, alu_z, rsp_z;
  logic        rsp_cout, err_orphan;
`ifdef ALU_ARB_STATS_EN
  logic [63:0] grant_cnt;
`endif

  int n_total = 0;
  int n_pass  = 0;

  always #5 clk = ~clk;

  alu_req_arbiter #(.NREQ(4), .DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .req_push(req_push), .req_stop(req_stop), .req_ctl(req_ctl),
    .req_a(req_a), .req_b(req_b), .req_ci(req_ci),
    .alu_pushin(alu_pushin), .alu_stopout(alu_stopout), .alu_ctl(alu_ctl),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ci(alu_ci),
    .alu_pushout(alu_pushout), .alu_stopin(alu_stopin),
    .alu_z(alu_z), .alu_cout(alu_cout),
    .rsp_push(rsp_push), .rsp_stop(rsp_stop), .rsp_z(rsp_z), .rsp_cout(rsp_cout),
`ifdef ALU_ARB_STATS_EN
    .grant_cnt(grant_cnt),
`endif
    .err_orphan(err_orphan)
  );

  typedef struct packed {
    logic       rst_before;
    logic [3:0] push;
    logic       stopout;
    logic       pushout;
    logic [3:0] rstop;
    logic [3:0] e_stop;
    logic       e_pushin;
    logic       chk_a;
    logic [7:0] e_a;
    logic [3:0] e_rsp;
    logic       e_stopin;
  } vec_t;

  vec_t vecs [15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req_push = '0; alu_stopout = 1'b0; alu_pushout = 1'b0; rsp_stop = '0;
    alu_z = '0; alu_cout = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  task automatic settle();
    #2;
  endtask

  initial begin
    rst     = 1'b0;
    req_ctl = 8'b11_10_01_00;
    req_ci  = 4'b1010;
    req_a   = {8'h13, 8'h12, 8'h11, 8'h10};
    req_b   = {8'h23, 8'h22, 8'h21, 8'h20};
    idle_inputs();

    //             rst push  so po rstop  e_stop  pin chkA a      rsp     sin
    vecs[0]  = '{1'b1, 4'hF, 1'b0, 1'b0, 4'h0, 4'b1110, 1'b1, 1'b1, 8'h10, 4'b0000, 1'b0};
    vecs[1]  = '{1'b0, 4'hF, 1'b0, 1'b1, 4'h0, 4'b1101, 1'b1, 1'b1, 8'h11, 4'b0001, 1'b0};
    vecs[2]  = '{1'b0, 4'hF, 1'b0, 1'b1, 4'h0, 4'b1011, 1'b1, 1'b1, 8'h12, 4'b0010, 1'b0};
    vecs[3]  = '{1'b0, 4'hF, 1'b0, 1'b1, 4'h0, 4'b0111, 1'b1, 1'b1, 8'h13, 4'b0100, 1'b0};
    vecs[4]  = '{1'b0, 4'hF, 1'b0, 1'b1, 4'h0, 4'b1110, 1'b1, 1'b1, 8'h10, 4'b1000, 1'b0};
    vecs[5]  = '{1'b1, 4'hF, 1'b0, 1'b0, 4'h0, 4'b1110, 1'b1, 1'b1, 8'h10, 4'b0000, 1'b0};
    vecs[6]  = '{1'b0, 4'hF, 1'b0, 1'b0, 4'h0, 4'b1101, 1'b1, 1'b1, 8'h11, 4'b0000, 1'b0};
    vecs[7]  = '{1'b0, 4'hF, 1'b0, 1'b0, 4'h0, 4'b1011, 1'b1, 1'b1, 8'h12, 4'b0000, 1'b0};
    vecs[8]  = '{1'b0, 4'hF, 1'b0, 1'b0, 4'h0, 4'b0111, 1'b1, 1'b1, 8'h13, 4'b0000, 1'b0};
    vecs[9]  = '{1'b0, 4'hF, 1'b0, 1'b0, 4'h0, 4'b1111, 1'b0, 1'b0, 8'h00, 4'b0000, 1'b0};
    vecs[10] = '{1'b0, 4'hF, 1'b0, 1'b0, 4'h0, 4'b1111, 1'b0, 1'b0, 8'h00, 4'b0000, 1'b0};
    vecs[11] = '{1'b0, 4'hF, 1'b0, 1'b1, 4'h0, 4'b1111, 1'b0, 1'b0, 8'h00, 4'b0001, 1'b0};
    vecs[12] = '{1'b0, 4'hF, 1'b0, 1'b0, 4'h0, 4'b1110, 1'b1, 1'b1, 8'h10, 4'b0000, 1'b0};
    vecs[13] = '{1'b0, 4'h0, 1'b0, 1'b1, 4'h2, 4'b1111, 1'b0, 1'b1, 8'h00, 4'b0010, 1'b1};
    vecs[14] = '{1'b0, 4'h0, 1'b0, 1'b1, 4'h0, 4'b1111, 1'b0, 1'b1, 8'h00, 4'b0010, 1'b0};

    // Reset state
    do_reset();
    settle();
    check("reset req_stop", 32'(req_stop), 32'hF);
    check("reset alu_pushin", 32'(alu_pushin), 32'h0);
    check("reset alu_a", 32'(alu_a), 32'h0);
    check("reset rsp_push", 32'(rsp_push), 32'h0);
    check("reset alu_stopin", 32'(alu_stopin), 32'h0);
    check("reset err_orphan", 32'(err_orphan), 32'h0);
    tick();

    // Round-robin, full FIFO, return routing and result stall from the table
    for (int i = 0; i < 15; i++) begin
      if (vecs[i].rst_before) do_reset();
      req_push    = vecs[i].push;
      alu_stopout = vecs[i].stopout;
      alu_pushout = vecs[i].pushout;
      rsp_stop    = vecs[i].rstop;
      settle();
      check($sformatf("vec%0d req_stop", i), 32'(req_stop), 32'(vecs[i].e_stop));
      check($sformatf("vec%0d alu_pushin", i), 32'(alu_pushin), 32'(vecs[i].e_pushin));
      if (vecs[i].chk_a) check($sformatf("vec%0d alu_a", i), 32'(alu_a), 32'(vecs[i].e_a));
      check($sformatf("vec%0d rsp_push", i), 32'(rsp_push), 32'(vecs[i].e_rsp));
      check($sformatf("vec%0d alu_stopin", i), 32'(alu_stopin), 32'(vecs[i].e_stopin));
      check($sformatf("vec%0d err_orphan", i), 32'(err_orphan), 32'h0);
      tick();
    end

    // Stall locks req1 even though rr search from 2 would pick req3
    do_reset();
    req_a[15:8] = 8'h55;
    req_push = 4'b0010;
    settle();
    check("lock pre-accept req_stop", 32'(req_stop), 32'hD);
    tick();
    req_a[15:8] = 8'h12; req_b[15:8] = 8'h34; req_a[31:24] = 8'h77;
    alu_stopout = 1'b1;
    for (int c = 0; c < 3; c++) begin
      req_push = (c == 0) ? 4'b0010 : 4'b1010;
      settle();
      check($sformatf("stall%0d alu_pushin", c), 32'(alu_pushin), 32'h1);
      check($sformatf("stall%0d alu_a", c), 32'(alu_a), 32'h12);
      check($sformatf("stall%0d alu_b", c), 32'(alu_b), 32'h34);
      check($sformatf("stall%0d req_stop", c), 32'(req_stop), 32'hF);
      tick();
    end
    alu_stopout = 1'b0;
    settle();
    check("stall release alu_a", 32'(alu_a), 32'h12);
    check("stall release req_stop", 32'(req_stop), 32'hD);
    tick();
    req_push = 4'b1000;
    settle();
    check("after stall alu_a req3", 32'(alu_a), 32'h77);
    check("after stall req_stop", 32'(req_stop), 32'h7);
    tick();
    req_a = {8'h13, 8'h12, 8'h11, 8'h10};
    req_b = {8'h23, 8'h22, 8'h21, 8'h20};

    // In-order return to requesters 2,0,2
    do_reset();
    req_push = 4'b0100; tick();
    req_push = 4'b0001; tick();
    req_push = 4'b0100; tick();
    req_push = 4'b0000;
    alu_pushout = 1'b1;
    for (int c = 0; c < 3; c++) begin
      logic [7:0] z_tab [3];
      logic [3:0] r_tab [3];
      z_tab = '{8'hA1, 8'hB2, 8'hC3};
      r_tab = '{4'b0100, 4'b0001, 4'b0100};
      alu_z = z_tab[c];
      settle();
      check($sformatf("ret%0d rsp_push", c), 32'(rsp_push), 32'(r_tab[c]));
      check($sformatf("ret%0d rsp_z", c), 32'(rsp_z), 32'(z_tab[c]));
      tick();
    end
    alu_pushout = 1'b0;
    settle();
    check("ret idle rsp_push", 32'(rsp_push), 32'h0);
    check("ret no orphan", 32'(err_orphan), 32'h0);
    tick();

    // Result back-pressure on head req0, then orphan detection
    do_reset();
    req_push = 4'b0001; tick();
    req_push = 4'b0000;
    alu_pushout = 1'b1; rsp_stop = 4'b0001;
    for (int c = 0; c < 2; c++) begin
      settle();
      check($sformatf("hold%0d alu_stopin", c), 32'(alu_stopin), 32'h1);
      check($sformatf("hold%0d rsp_push", c), 32'(rsp_push), 32'h1);
      tick();
    end
    rsp_stop = 4'b0000;
    settle();
    check("deliver alu_stopin", 32'(alu_stopin), 32'h0);
    check("deliver rsp_push", 32'(rsp_push), 32'h1);
    tick();
    settle();
    check("empty rsp_push", 32'(rsp_push), 32'h0);
    check("orphan not yet", 32'(err_orphan), 32'h0);
    tick();
    alu_pushout = 1'b0;
    settle();
    check("orphan set", 32'(err_orphan), 32'h1);
    tick();
    tick();
    settle();
    check("orphan sticky", 32'(err_orphan), 32'h1);
    rst = 1'b0;
    tick();
    settle();
    check("orphan cleared by reset", 32'(err_orphan), 32'h0);
    rst = 1'b1;
    tick();

`ifdef ALU_ARB_STATS_EN
    do_reset();
    req_push = 4'b0010;
    for (int c = 0; c < 3; c++) tick();
    req_push = 4'b0000;
    settle();
    check("grant_cnt req1", 32'(grant_cnt[31:16]), 32'd3);
    check("grant_cnt req0", 32'(grant_cnt[15:0]), 32'd0);
    tick();
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
